// File: rtl/mem_seq_arbiter_if.sv
// rtl/mem_seq_arbiter_if.sv - requester ports and RAM control pins of the sequencing arbiter
// master is the arbiter's view; slave is the requesters plus RAM seen from outside.
interface mem_seq_arbiter_if;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;

    logic        d_req;
    logic        d_rw;
    logic [1:0]  d_dtype;
    logic [7:0]  d_addr;
    logic [31:0] d_wdata0;
    logic [31:0] d_wdata1;
    logic        d_ack;
    logic [31:0] d_rdata0;
    logic [31:0] d_rdata1;
    logic        err;

    logic        ram_enable;
    logic        ram_mfa;
    logic        ram_r_w;
    logic [1:0]  ram_dtype;
    logic        ram_dwp1;
    logic [7:0]  ram_addr;
    logic [31:0] ram_data_in;
    logic [31:0] ram_data_out;
    logic        ram_mfc;

    modport master (
        input  if_req, if_addr, d_req, d_rw, d_dtype, d_addr, d_wdata0, d_wdata1,
               ram_data_out, ram_mfc,
        output if_ack, if_rdata, d_ack, d_rdata0, d_rdata1, err,
               ram_enable, ram_mfa, ram_r_w, ram_dtype, ram_dwp1, ram_addr, ram_data_in
    );

    modport slave (
        output if_req, if_addr, d_req, d_rw, d_dtype, d_addr, d_wdata0, d_wdata1,
               ram_data_out, ram_mfc,
        input  if_ack, if_rdata, d_ack, d_rdata0, d_rdata1, err,
               ram_enable, ram_mfa, ram_r_w, ram_dtype, ram_dwp1, ram_addr, ram_data_in
    );
endinterface

// File: rtl/mem_seq_arbiter.sv
// rtl/mem_seq_arbiter.sv - round-robin fetch/data arbiter driving the async RAM mfa/mfc handshake
// RAM pins are registered on entry to each state so they are stable for the whole state.
module mem_seq_arbiter #(
    parameter int TIMEOUT_CYC = 32
) (
    input logic               clk,
    input logic               reset,
    mem_seq_arbiter_if.master bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SETUP   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_REL_EN  = 3'd4;
    localparam logic [2:0] S_REL_MFA = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    localparam logic [1:0] DT_WORD  = 2'b10;
    localparam logic [1:0] DT_DWORD = 2'b11;

    localparam int               CNT_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_FLUSH = CNT_W'(2);

    logic [2:0]       state;
    logic             mfc_meta;
    logic             mfc_s;
    logic             prio_d;
    logic             port_d;
    logic             phase2;
    logic             timed_out;
    logic [1:0]       cur_dtype;
    logic [31:0]      wdata1;
    logic [CNT_W-1:0] wait_cnt;

    logic             any_req;
    logic             pick_d;
    logic             g_rw;
    logic [1:0]       g_dtype;
    logic [7:0]       g_addr;
    logic [31:0]      g_wdata;

    always_comb begin
        any_req = bus.if_req | bus.d_req;
        pick_d  = bus.d_req & (~bus.if_req | prio_d);
        g_rw    = pick_d & bus.d_rw;
        g_dtype = pick_d ? bus.d_dtype : DT_WORD;
        g_addr  = pick_d ? bus.d_addr : bus.if_addr;
        g_wdata = pick_d ? bus.d_wdata0 : 32'd0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mfc_meta <= 1'b0;
            mfc_s    <= 1'b0;
        end else begin
            mfc_meta <= bus.ram_mfc;
            mfc_s    <= mfc_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_IDLE;
            prio_d          <= 1'b0;
            port_d          <= 1'b0;
            phase2          <= 1'b0;
            timed_out       <= 1'b0;
            cur_dtype       <= 2'b00;
            wdata1          <= 32'd0;
            wait_cnt        <= '0;
            bus.if_ack      <= 1'b0;
            bus.d_ack       <= 1'b0;
            bus.err         <= 1'b0;
            bus.if_rdata    <= 32'd0;
            bus.d_rdata0    <= 32'd0;
            bus.d_rdata1    <= 32'd0;
            bus.ram_enable  <= 1'b1;
            bus.ram_mfa     <= 1'b0;
            bus.ram_r_w     <= 1'b0;
            bus.ram_dtype   <= 2'b00;
            bus.ram_dwp1    <= 1'b1;
            bus.ram_addr    <= 8'd0;
            bus.ram_data_in <= 32'd0;
        end else begin
            bus.if_ack <= 1'b0;
            bus.d_ack  <= 1'b0;
            bus.err    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        port_d          <= pick_d;
                        prio_d          <= ~pick_d;
                        phase2          <= 1'b0;
                        cur_dtype       <= g_dtype;
                        wdata1          <= bus.d_wdata1;
                        bus.ram_r_w     <= g_rw;
                        bus.ram_dtype   <= g_dtype;
                        bus.ram_addr    <= g_addr;
                        bus.ram_data_in <= g_wdata;
                        bus.ram_dwp1    <= 1'b1;
                        bus.ram_enable  <= 1'b0;
                        state           <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    bus.ram_mfa <= 1'b1;
                    wait_cnt    <= '0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    // The first two cycles may still show the previous access's mfc.
                    if (wait_cnt >= CNT_FLUSH && mfc_s) begin
                        state <= S_CAPTURE;
                    end else if (wait_cnt == CNT_MAX) begin
                        timed_out      <= 1'b1;
                        bus.ram_enable <= 1'b1;
                        state          <= S_REL_EN;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    if (!port_d)
                        bus.if_rdata <= bus.ram_data_out;
                    else if (!phase2)
                        bus.d_rdata0 <= bus.ram_data_out;
                    else
                        bus.d_rdata1 <= bus.ram_data_out;
                    bus.ram_enable <= 1'b1;
                    state          <= S_REL_EN;
                end
                S_REL_EN: begin
                    bus.ram_mfa <= 1'b0;
                    state       <= S_REL_MFA;
                end
                S_REL_MFA: begin
                    if (cur_dtype == DT_DWORD && !phase2 && !timed_out) begin
                        phase2          <= 1'b1;
                        bus.ram_data_in <= wdata1;
                        bus.ram_dwp1    <= 1'b0;
                        bus.ram_enable  <= 1'b0;
                        state           <= S_SETUP;
                    end else begin
                        bus.if_ack <= ~port_d;
                        bus.d_ack  <= port_d;
                        bus.err    <= timed_out;
                        timed_out  <= 1'b0;
                        state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_seq_arbiter.sv
// tb/tb_mem_seq_arbiter.sv - randomized self-checking bench for mem_seq_arbiter
// Holds a behavioural async RAM on the pins and a request-level memory reference.
module tb_mem_seq_arbiter;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    mem_seq_arbiter_if bus();

    mem_seq_arbiter #(.TIMEOUT_CYC(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Async RAM: big-endian, aligns addresses itself, echoes write data.
    logic [7:0] ram_mem [256];
    int         ram_delay   = 1;
    bit         ram_respond = 1'b1;
    logic       mfc_set     = 1'b0;
    int         mfa_viol    = 0;
    bit         dwp_log [$];

    assign bus.ram_mfc = mfc_set & bus.ram_mfa & ram_respond;

    task automatic ram_access;
        int n;
        int base;
        logic [31:0] d;
        n = (bus.ram_dtype == 2'b00) ? 1 : (bus.ram_dtype == 2'b01) ? 2 : 4;
        if (bus.ram_dtype == 2'b11)
            base = (int'(bus.ram_addr) & 'hF8) + (bus.ram_dwp1 ? 0 : 4);
        else
            base = int'(bus.ram_addr) & ~(n - 1);
        d = 32'd0;
        if (bus.ram_r_w) begin
            for (int i = 0; i < n; i++) ram_mem[base + i] = bus.ram_data_in[8*(n-1-i) +: 8];
            d = bus.ram_data_in;
        end else begin
            for (int i = 0; i < n; i++) d = (d << 8) | 32'(ram_mem[base + i]);
        end
        bus.ram_data_out = d;
    endtask

    always @(posedge bus.ram_mfa) begin
        mfc_set = 1'b0;
        dwp_log.push_back(bus.ram_dwp1);
        if (!bus.ram_enable && ram_respond) begin
            ram_access();
            #(ram_delay);
            mfc_set = 1'b1;
        end
    end

    always @(negedge bus.ram_mfa) if (!reset && bus.ram_enable !== 1'b1) mfa_viol++;

    // Request-level reference memory.
    logic [7:0] ref_mem [256];

    function automatic int acc_bytes(input logic [1:0] dtype);
        return (dtype == 2'b11) ? 8 : (1 << dtype);
    endfunction

    function automatic logic [63:0] ref_read(input logic [1:0] dtype, input logic [7:0] addr);
        int n;
        int base;
        logic [63:0] v;
        n = acc_bytes(dtype);
        base = int'(addr) - (int'(addr) % n);
        v = 64'd0;
        for (int i = 0; i < n; i++) v = (v << 8) | 64'(ref_mem[base + i]);
        return v;
    endfunction

    task automatic ref_write(input logic [1:0] dtype, input logic [7:0] addr,
                             input logic [31:0] w0, input logic [31:0] w1);
        int n;
        int base;
        logic [63:0] v;
        n = acc_bytes(dtype);
        base = int'(addr) - (int'(addr) % n);
        v = (n == 8) ? {w0, w1} : {32'd0, w0};
        for (int i = 0; i < n; i++) ref_mem[base + i] = v[8*(n-1-i) +: 8];
    endtask

    task automatic run_fetch(input logic [7:0] addr, output int lat, output bit acked,
                             output bit stray, output bit errp);
        @(negedge clk);
        bus.if_addr = addr;
        bus.if_req  = 1'b1;
        lat = 0; acked = 1'b0; stray = 1'b0; errp = 1'b0;
        while (!acked && lat < 300) begin
            @(negedge clk);
            lat++;
            if (bus.d_ack) stray = 1'b1;
            if (bus.if_ack) begin acked = 1'b1; errp = bus.err; end
        end
        bus.if_req = 1'b0;
    endtask

    task automatic run_data(input bit rw, input logic [1:0] dtype, input logic [7:0] addr,
                            input logic [31:0] w0, input logic [31:0] w1, output int lat,
                            output bit acked, output bit stray, output bit errp);
        @(negedge clk);
        bus.d_rw = rw; bus.d_dtype = dtype; bus.d_addr = addr;
        bus.d_wdata0 = w0; bus.d_wdata1 = w1;
        bus.d_req = 1'b1;
        lat = 0; acked = 1'b0; stray = 1'b0; errp = 1'b0;
        while (!acked && lat < 300) begin
            @(negedge clk);
            lat++;
            if (bus.if_ack) stray = 1'b1;
            if (bus.d_ack) begin acked = 1'b1; errp = bus.err; end
        end
        bus.d_req = 1'b0;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.if_ack, bus.d_ack, bus.err, bus.ram_enable, bus.ram_mfa, bus.ram_r_w,
             bus.ram_dtype, bus.ram_dwp1} !== 9'b000100001) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b want 000100001", {bus.if_ack, bus.d_ack, bus.err,
                     bus.ram_enable, bus.ram_mfa, bus.ram_r_w, bus.ram_dtype, bus.ram_dwp1});
        end
        n_checks++;
        if ({bus.if_rdata, bus.d_rdata0, bus.d_rdata1, bus.ram_data_in, bus.ram_addr} !== 136'd0) begin
            n_errors++;
            $display("FAIL reset_data: got %h %h %h %h %h want all zero", bus.if_rdata,
                     bus.d_rdata0, bus.d_rdata1, bus.ram_data_in, bus.ram_addr);
        end
        reset = 1'b0;
    endtask

    task automatic test_fetch_read;
        int lat; bit acked, stray, errp;
        run_fetch(8'h10, lat, acked, stray, errp);
        n_checks++;
        if (lat !== 8 || !acked) begin
            n_errors++; $display("FAIL fetch_latency: got %0d want 8", lat);
        end
        n_checks++;
        if (bus.if_rdata !== 32'h11223344) begin
            n_errors++; $display("FAIL fetch_data: got %h want 11223344", bus.if_rdata);
        end
        n_checks++;
        if (stray || errp) begin
            n_errors++; $display("FAIL fetch_no_dack: got d_ack=%0b err=%0b want 0 0", stray, errp);
        end
    endtask

    task automatic test_half_write_read;
        int lat; bit acked, stray, errp;
        run_data(1'b1, 2'b01, 8'h20, 32'h0000BEEF, 32'd0, lat, acked, stray, errp);
        ref_write(2'b01, 8'h20, 32'h0000BEEF, 32'd0);
        n_checks++;
        if (lat !== 8 || errp || stray) begin
            n_errors++; $display("FAIL half_write_ack: got lat=%0d err=%0b want lat=8 err=0", lat, errp);
        end
        n_checks++;
        if (ram_mem[8'h20] !== 8'hBE || ram_mem[8'h21] !== 8'hEF) begin
            n_errors++;
            $display("FAIL half_write_ram: got %h%h want BEEF", ram_mem[8'h20], ram_mem[8'h21]);
        end
        run_data(1'b0, 2'b01, 8'h20, 32'd0, 32'd0, lat, acked, stray, errp);
        n_checks++;
        if (bus.d_rdata0 !== 32'h0000BEEF || !acked) begin
            n_errors++; $display("FAIL half_read: got %h want 0000beef", bus.d_rdata0);
        end
    endtask

    task automatic test_dword;
        int lat; bit acked, stray, errp;
        logic [63:0] expv;
        run_data(1'b1, 2'b11, 8'h43, 32'hCAFEF00D, 32'h12345678, lat, acked, stray, errp);
        ref_write(2'b11, 8'h43, 32'hCAFEF00D, 32'h12345678);
        n_checks++;
        if (lat !== 15 || errp) begin
            n_errors++; $display("FAIL dword_write_latency: got %0d want 15", lat);
        end
        expv = 64'hCAFEF00D12345678;
        for (int i = 0; i < 8; i++) begin
            n_checks++;
            if (ram_mem[8'h40 + i] !== expv[8*(7-i) +: 8]) begin
                n_errors++;
                $display("FAIL dword_ram_%0d: got %h want %h", i, ram_mem[8'h40 + i], expv[8*(7-i) +: 8]);
            end
        end
        dwp_log.delete();
        run_data(1'b0, 2'b11, 8'h43, 32'd0, 32'd0, lat, acked, stray, errp);
        n_checks++;
        if (bus.d_rdata0 !== 32'hCAFEF00D || bus.d_rdata1 !== 32'h12345678) begin
            n_errors++;
            $display("FAIL dword_read: got %h %h want cafef00d 12345678", bus.d_rdata0, bus.d_rdata1);
        end
        n_checks++;
        if (lat !== 15) begin
            n_errors++; $display("FAIL dword_read_latency: got %0d want 15", lat);
        end
        n_checks++;
        if (dwp_log.size() != 2 || dwp_log[0] != 1'b1 || dwp_log[1] != 1'b0) begin
            n_errors++; $display("FAIL dword_dwp1: got %0d phases want 1 then 0", dwp_log.size());
        end
    endtask

    task automatic test_contention;
        int order [$];
        int cyc;
        int viol0;
        logic [63:0] expv;
        viol0 = mfa_viol;
        @(negedge clk);
        bus.if_addr = 8'h14;
        bus.d_rw = 1'b0; bus.d_dtype = 2'b10; bus.d_addr = 8'h10;
        bus.if_req = 1'b1; bus.d_req = 1'b1;
        cyc = 0;
        while (order.size() < 4 && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (bus.if_ack) order.push_back(0);
            if (bus.d_ack) order.push_back(1);
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        n_checks++;
        if (order.size() != 4) begin
            n_errors++; $display("FAIL contention_count: got %0d acks want 4", order.size());
        end
        for (int i = 0; i < order.size(); i++) begin
            n_checks++;
            if (order[i] != (i % 2)) begin
                n_errors++; $display("FAIL contention_order_%0d: got port %0d want %0d", i, order[i], i % 2);
            end
        end
        expv = ref_read(2'b10, 8'h14);
        n_checks++;
        if (bus.if_rdata !== expv[31:0]) begin
            n_errors++; $display("FAIL contention_fetch_data: got %h want %h", bus.if_rdata, expv[31:0]);
        end
        expv = ref_read(2'b10, 8'h10);
        n_checks++;
        if (bus.d_rdata0 !== expv[31:0]) begin
            n_errors++; $display("FAIL contention_data_data: got %h want %h", bus.d_rdata0, expv[31:0]);
        end
        n_checks++;
        if (mfa_viol != viol0) begin
            n_errors++; $display("FAIL mfa_fall_enabled: got %0d events want 0", mfa_viol - viol0);
        end
    endtask

    task automatic test_timeout;
        int lat; bit acked, stray, errp;
        logic [63:0] expv;
        run_data(1'b0, 2'b01, 8'h20, 32'd0, 32'd0, lat, acked, stray, errp);
        expv = ref_read(2'b01, 8'h20);
        ram_respond = 1'b0;
        run_data(1'b0, 2'b10, 8'h24, 32'd0, 32'd0, lat, acked, stray, errp);
        n_checks++;
        if (!acked || !errp) begin
            n_errors++; $display("FAIL timeout_err: got ack=%0b err=%0b want 1 1", acked, errp);
        end
        n_checks++;
        if (bus.d_rdata0 !== expv[31:0]) begin
            n_errors++; $display("FAIL timeout_rdata: got %h want %h", bus.d_rdata0, expv[31:0]);
        end
        @(negedge clk);
        n_checks++;
        if (bus.ram_enable !== 1'b1 || bus.ram_mfa !== 1'b0 || bus.err !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_release: got en=%0b mfa=%0b err=%0b want 1 0 0",
                     bus.ram_enable, bus.ram_mfa, bus.err);
        end
        ram_respond = 1'b1;
    endtask

    task automatic test_random;
        int lat; bit acked, stray, errp;
        bit rw;
        logic [1:0] dt;
        logic [7:0] a;
        logic [31:0] w0, w1;
        logic [63:0] expv;
        for (int k = 0; k < 40; k++) begin
            ram_delay = $urandom_range(1, 45);
            a = 8'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                run_fetch(a, lat, acked, stray, errp);
                expv = ref_read(2'b10, a);
                n_checks++;
                if (!acked || errp || stray || lat < 8 || bus.if_rdata !== expv[31:0]) begin
                    n_errors++;
                    $display("FAIL rand_fetch_%0d: got %h lat=%0d err=%0b want %h", k,
                             bus.if_rdata, lat, errp, expv[31:0]);
                end
            end else begin
                rw = 1'($urandom); dt = 2'($urandom); w0 = $urandom; w1 = $urandom;
                run_data(rw, dt, a, w0, w1, lat, acked, stray, errp);
                n_checks++;
                if (!acked || errp || stray || lat < ((dt == 2'b11) ? 15 : 8)) begin
                    n_errors++; $display("FAIL rand_ack_%0d: got ack=%0b err=%0b lat=%0d", k, acked, errp, lat);
                end
                if (rw) begin
                    ref_write(dt, a, w0, w1);
                end else begin
                    expv = ref_read(dt, a);
                    n_checks++;
                    if (bus.d_rdata0 !== ((dt == 2'b11) ? expv[63:32] : expv[31:0]) ||
                        (dt == 2'b11 && bus.d_rdata1 !== expv[31:0])) begin
                        n_errors++;
                        $display("FAIL rand_read_%0d: got %h %h want %h", k, bus.d_rdata0, bus.d_rdata1, expv);
                    end
                end
            end
        end
        ram_delay = 1;
    endtask

    task automatic test_reset_mid;
        int lat; bit acked, stray, errp;
        bit seen;
        logic [63:0] expv;
        @(negedge clk);
        bus.d_rw = 1'b1; bus.d_dtype = 2'b11; bus.d_addr = 8'h80;
        bus.d_wdata0 = 32'hA5A5A5A5; bus.d_wdata1 = 32'h5A5A5A5A;
        bus.d_req = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.ram_mfa !== 1'b1 || bus.ram_enable !== 1'b0 || bus.ram_dwp1 !== 1'b1) begin
            n_errors++; $display("FAIL midreset_wait: got mfa=%0b en=%0b want 1 0", bus.ram_mfa, bus.ram_enable);
        end
        #1 reset = 1'b1;
        #1;
        n_checks++;
        if ({bus.ram_enable, bus.ram_mfa, bus.ram_dwp1, bus.d_ack, bus.if_ack, bus.err} !== 6'b101000 ||
            bus.ram_addr !== 8'd0 || bus.d_rdata0 !== 32'd0) begin
            n_errors++;
            $display("FAIL midreset_outputs: got en=%0b mfa=%0b dwp1=%0b dack=%0b addr=%h want 1 0 1 0 00",
                     bus.ram_enable, bus.ram_mfa, bus.ram_dwp1, bus.d_ack, bus.ram_addr);
        end
        bus.d_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (bus.d_ack || bus.if_ack) seen = 1'b1;
        end
        n_checks++;
        if (seen) begin
            n_errors++; $display("FAIL midreset_no_ack: got ack after reset want none");
        end
        run_fetch(8'h10, lat, acked, stray, errp);
        expv = ref_read(2'b10, 8'h10);
        n_checks++;
        if (lat !== 8 || bus.if_rdata !== expv[31:0]) begin
            n_errors++;
            $display("FAIL midreset_fetch: got %h lat=%0d want %h lat=8", bus.if_rdata, lat, expv[31:0]);
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.if_req = 1'b0; bus.if_addr = 8'd0;
        bus.d_req = 1'b0; bus.d_rw = 1'b0; bus.d_dtype = 2'b00; bus.d_addr = 8'd0;
        bus.d_wdata0 = 32'd0; bus.d_wdata1 = 32'd0;
        bus.ram_data_out = 32'd0;
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = 8'($urandom);
            ref_mem[i] = ram_mem[i];
        end
        ram_mem[8'h10] = 8'h11; ram_mem[8'h11] = 8'h22; ram_mem[8'h12] = 8'h33; ram_mem[8'h13] = 8'h44;
        ref_mem[8'h10] = 8'h11; ref_mem[8'h11] = 8'h22; ref_mem[8'h12] = 8'h33; ref_mem[8'h13] = 8'h44;
        test_reset();
        test_fetch_read();
        test_half_write_read();
        test_dword();
        test_contention();
        test_timeout();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mem_seq_arbiter.md
# mem_seq_arbiter

Clocked front end for the asynchronous 256-byte RAM. It arbitrates between the instruction-fetch port and the data port, and drives the RAM's mfa/mfc handshake. It splits DWORD transfers into their two word phases and returns read data to the winning requester. It sits between the CPU control unit and the RAM, and is the only block that drives RAM control pins.

## Interface
- `TIMEOUT_CYC`, default 32: WAIT cycles without a synchronized mfc before the access is aborted.
- `clk  in  1`: system clock; all state changes on the rising edge.
- `reset  in  1`: asynchronous, active-high.
- `if_req  in  1`: fetch request, level; held until `if_ack`.
- `if_addr  in  8`: fetch byte address, sampled at grant; always a WORD read.
- `if_ack  out  1`: one-cycle completion pulse.
- `if_rdata  out  32`: fetch data; valid from `if_ack` until the next fetch grant.
- `d_req  in  1`: data request, level; held until `d_ack`.
- `d_rw  in  1`: 1 = write, 0 = read; sampled at grant.
- `d_dtype  in  2`: 00 BYTE, 01 HALF, 10 WORD, 11 DWORD; sampled at grant.
- `d_addr  in  8`: byte address; sampled at grant.
- `d_wdata0  in  32`: write data, phase 1 (the only phase for non-DWORD).
- `d_wdata1  in  32`: DWORD phase-2 write data.
- `d_ack  out  1`: one-cycle completion pulse.
- `d_rdata0  out  32`, `d_rdata1  out  32`: read data for phase 1 and phase 2.
- `err  out  1`: one-cycle pulse coincident with an ack when the access timed out.
- `ram_enable  out  1`: RAM enable, active-low.
- `ram_mfa  out  1`: RAM strobe.
- `ram_r_w  out  1`, `ram_dtype  out  2`, `ram_dwp1  out  1`, `ram_addr  out  8`, `ram_data_in  out  32`: RAM command and write-data pins.
- `ram_data_out  in  32`: RAM read data.
- `ram_mfc  in  1`: RAM completion; asynchronous to `clk`.

## Operation
- `ram_mfc` passes through a 2-flop synchronizer; only the synchronized `mfc_s` is used.
- The RAM starts an access on every mfa edge while enable is low. Therefore mfa may only fall while `ram_enable` is 1.
- FSM states: IDLE, SETUP, WAIT, CAPTURE, REL_EN, REL_MFA, DONE.
- **IDLE**
  - With no request pending, stay in IDLE.
  - With one request pending, grant it.
  - With both pending, grant round-robin: the port not granted last wins. After reset, the fetch port has priority.
  - At grant, latch port, rw, dtype, addr and wdata; set phase = 1. Fetch forces rw = 0, dtype = WORD. Go to SETUP.
- **SETUP**: drive `ram_addr`, `ram_dtype`, `ram_r_w`, `ram_data_in`, and `ram_dwp1` = (phase==1); `ram_enable` = 0; mfa stays 0. Go to WAIT.
- **WAIT**
  - Raise `ram_mfa` = 1 and clear `wait_cnt`.
  - Ignore `mfc_s` while `wait_cnt` < 2; this flushes stale mfc through the synchronizer.
  - Exit to CAPTURE on the first cycle with `wait_cnt` ≥ 2 and `mfc_s` = 1.
  - If `wait_cnt` reaches `TIMEOUT_CYC`, set the timeout flag and go to REL_EN.
- **CAPTURE**: latch `ram_data_out` into `if_rdata` or `d_rdata0`/`d_rdata1` according to port and phase. This happens for writes too, since the RAM echoes write data. Go to REL_EN.
- **REL_EN**: `ram_enable` = 1; mfa still 1. Go to REL_MFA.
- **REL_MFA**: `ram_mfa` = 0. Next state:
  - SETUP with phase = 2, if dtype = DWORD, phase = 1 and no timeout;
  - otherwise DONE.
- **DONE**
  - Pulse the granted port's ack for one cycle, and `err` if the timeout flag is set; clear the flag.
  - Go to IDLE. A request still high in IDLE in the next cycle is treated as a new request.
- Address alignment is the RAM's job; addresses pass through unmodified.
- After a timeout, read-data registers for the aborted phase keep their old values.

## Timing
- Reset values (asynchronous, immediate):
  - FSM in IDLE, round-robin pointer at fetch.
  - `if_ack`, `d_ack`, `err` = 0.
  - `if_rdata`, `d_rdata0`, `d_rdata1` = 0.
  - `ram_enable` = 1, `ram_mfa` = 0, `ram_r_w` = 0, `ram_dtype` = 00, `ram_dwp1` = 1, `ram_addr` = 0, `ram_data_in` = 0.
- Reset mid-access abandons the transfer with no ack. mfa falling while enable = 1 is legal.
- Cycle numbering, with grant registered at cycle G:
  - G+1 SETUP;
  - G+2 mfa high;
  - earliest CAPTURE G+5;
  - REL_EN G+6;
  - REL_MFA G+7;
  - ack G+8.
- DWORD phase 2 starts SETUP at G+8; earliest ack G+15.
- Each extra cycle of mfc delay adds 1 cycle per phase.
- Requests arriving during a transfer wait. Requesters must not change sampled inputs before their ack.

## Test plan
- **Fetch read**: preload RAM[0x10..0x13] = 11 22 33 44; `if_req`, addr 0x10 → `if_ack` at G+8, `if_rdata` = 0x11223344, `d_ack` never asserted.
- **Data HALF write then read**: HALF write of 0x0000BEEF at 0x20, then HALF read of 0x20 → RAM[0x20] = 0xBE, RAM[0x21] = 0xEF; `d_rdata0` = 0x0000BEEF.
- **DWORD write then read**: wdata0 = 0xCAFEF00D, wdata1 = 0x12345678 at 0x43 → RAM[0x40..0x47] filled; the read returns `d_rdata0` = 0xCAFEF00D, `d_rdata1` = 0x12345678; `ram_dwp1` is 1 then 0; ack at G+15.
- **Contention**: `if_req` and `d_req` rise together and stay high for 4 transfers → grants alternate fetch, data, fetch, data; `ram_mfa` never falls while `ram_enable` = 0.
- **Timeout**: `ram_mfc` tied low, `TIMEOUT_CYC` = 32 → `d_ack` and `err` pulse together; `d_rdata0` unchanged; `ram_enable` = 1 and `ram_mfa` = 0 afterwards.
- **Reset**: assert `reset` during WAIT of a DWORD phase 1 → outputs at reset values immediately, no ack; a fetch after release completes normally.
